// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and defaults for the multiplier-sharing arbiter.
// The watchdog is compiled in when MULT_ARB_WDOG_EN is defined; see mult_arbiter.
package mult_arb_pkg;

  // Controller states: accept a request, kick the core, wait for it, reply.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_PROD_W  = 2 * DEF_WIDTH;

  // Full unsigned product width for a given operand width.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mult_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Returns the first requester at or
// after i_ptr (ascending, wrapping) as a one-hot grant plus its binary index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum;

  // Rotate so that bit 0 is the requester rr_ptr points at.
  assign w_req2 = {i_req, i_req};
  assign w_rot  = NREQ'(w_req2 >> i_ptr);

  // Lowest set bit of the rotated vector is the winner's offset from rr_ptr.
  always_comb begin
    o_any = 1'b0;
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        w_off = IW'(k);
      end
    end
  end

  // Undo the rotation modulo NREQ (NREQ need not be a power of two).
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : w_sum[IW-1:0];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign o_grant[gi] = o_any && (o_idx == IW'(gi));
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one start/done sequential multiplier among NREQ requesters
// in round-robin order and returns each product with a one-cycle pulse.
// Define MULT_ARB_WDOG_EN to add a WAIT-state watchdog that aborts after TIMEOUT
// cycles with resp_err=1 and a zero product; otherwise WAIT is unbounded.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_mlier,
  input  logic [NREQ*WIDTH-1:0]   req_mcand,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    resp_err,
  output logic                    core_start,
  output logic [WIDTH-1:0]        core_mlier,
  output logic [WIDTH-1:0]        core_mcand,
  input  logic                    core_done,
  input  logic [2*WIDTH-1:0]      core_product,
  output logic                    busy
);

  localparam int PW = prod_width(WIDTH);
  localparam int IW = $clog2(NREQ);

  state_t          r_state, w_state_next;
  logic [IW-1:0]   r_rr_ptr, r_grant_idx, w_idx;
  logic [NREQ-1:0] w_grant;
  logic            w_any, w_accept, w_timeout;
  logic [WIDTH-1:0] r_mlier, r_mcand;
  logic [PW-1:0]   r_product;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Accept only in IDLE; gated by rst so req_ready reads 0 during reset.
  assign w_accept  = (r_state == IDLE) && w_any && !rst;
  assign req_ready = w_accept ? w_grant : '0;

`ifdef MULT_ARB_WDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wdog_cnt;
  logic          r_err;

  // The last permitted WAIT cycle without done is the abort point.
  assign w_timeout = (r_state == WAIT) && !core_done && (r_wdog_cnt == CW'(TIMEOUT - 1));

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_wdog_cnt <= '0;
    else if (r_state != WAIT)  r_wdog_cnt <= '0;
    else                       r_wdog_cnt <= r_wdog_cnt + CW'(1);
  end

  // Remember whether the current response is an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_err <= 1'b0;
    else if (w_timeout)                      r_err <= 1'b1;
    else if (r_state == WAIT && core_done)   r_err <= 1'b0;
  end

  assign resp_err = (r_state == RESP) && r_err;
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; core_done matters only in WAIT.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = ISSUE;
      ISSUE:   w_state_next = WAIT;
      WAIT:    if (core_done || w_timeout) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Latch the winner's operands and index, and advance rr_ptr past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mlier     <= '0;
      r_mcand     <= '0;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else if (w_accept) begin
      r_mlier     <= req_mlier[w_idx*WIDTH +: WIDTH];
      r_mcand     <= req_mcand[w_idx*WIDTH +: WIDTH];
      r_grant_idx <= w_idx;
      r_rr_ptr    <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
    end
  end

  // Capture the core result on done; an aborted operation returns zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_product <= '0;
    else if (r_state == WAIT && core_done)   r_product <= core_product;
    else if (w_timeout)                      r_product <= '0;
  end

  assign core_start   = (r_state == ISSUE);
  assign busy         = (r_state != IDLE);
  assign core_mlier   = r_mlier;
  assign core_mcand   = r_mcand;
  assign resp_product = r_product;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
    assign resp_valid[gi] = (r_state == RESP) && (r_grant_idx == IW'(gi));
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed stimulus with a response/grant scoreboard checked by
// an independent monitor; includes a behavioural sequential-multiplier core.
module tb_mult_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  typedef struct {
    int          idx;
    logic [63:0] prod;
    logic        err;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_mlier, req_mcand;
  logic [NREQ-1:0]       req_ready, resp_valid;
  logic [63:0]           resp_product;
  logic                  resp_err, core_start, busy;
  logic [WIDTH-1:0]      core_mlier, core_mcand;
  logic                  core_done, core_done_m, core_spur;
  logic [63:0]           core_product, core_prod_m;

  int   core_lat;
  logic core_hang;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   t_ready, t_start, t_resp;
  logic [WIDTH-1:0] s_mlier, s_mcand;

  exp_t exp_q[$];
  int   grant_q[$];

  assign core_done    = core_done_m | core_spur;
  assign core_product = core_spur ? 64'hBAD0BAD0BAD0BAD0 : core_prod_m;

  mult_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mlier(req_mlier), .req_mcand(req_mcand),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_product(resp_product),
    .resp_err(resp_err), .core_start(core_start), .core_mlier(core_mlier),
    .core_mcand(core_mcand), .core_done(core_done), .core_product(core_product),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic request(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prod);
    exp_t e;
    req_mlier[i*WIDTH +: WIDTH] = a;
    req_mcand[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
    e.idx = i; e.prod = prod; e.err = 1'b0;
    grant_q.push_back(i);
    exp_q.push_back(e);
    $display("issue: req %0d  %h x %h  expect %h", i, a, b, prod);
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || grant_q.size() != 0 || busy || req_valid != 0) && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 64'(exp_q.size() + grant_q.size()), 64'd0);
    exp_q.delete();
    grant_q.delete();
  endtask

  task automatic wait_start(input string name);
    int k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (core_start) break;
      k++;
    end
    check(name, 64'(k < 50), 64'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"},    64'(req_ready),  64'd0);
    check({tag, "_resp_valid"},   64'(resp_valid), 64'd0);
    check({tag, "_resp_product"}, resp_product,    64'd0);
    check({tag, "_resp_err"},     64'(resp_err),   64'd0);
    check({tag, "_core_start"},   64'(core_start), 64'd0);
    check({tag, "_core_mlier"},   64'(core_mlier), 64'd0);
    check({tag, "_core_mcand"},   64'(core_mcand), 64'd0);
    check({tag, "_busy"},         64'(busy),       64'd0);
  endtask

  // Behavioural core: product appears with done L cycles after the start cycle.
  initial begin
    logic [31:0] a, b;
    core_done_m = 1'b0;
    core_prod_m = '0;
    forever begin
      @(negedge clk);
      if (core_start && !core_hang) begin
        a = core_mlier;
        b = core_mcand;
        repeat (core_lat) @(posedge clk);
        #1;
        core_done_m = 1'b1;
        core_prod_m = {32'd0, a} * {32'd0, b};
        @(posedge clk);
        #1;
        core_done_m = 1'b0;
      end
    end
  end

  // Requesters drop req_valid after the cycle in which they were accepted.
  initial begin
    logic [NREQ-1:0] drop;
    forever begin
      @(negedge clk);
      drop = req_ready;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~drop;
    end
  end

  // Monitor: compares grants and responses against the scoreboard queues.
  initial begin
    int   g;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != 0) begin
          if (grant_q.size() == 0) check("unexpected_grant", 64'(req_ready), 64'd0);
          else begin
            g = grant_q.pop_front();
            check("grant", 64'(req_ready), 64'd1 << g);
          end
          t_ready = cyc;
        end
        if (core_start) begin
          t_start = cyc;
          s_mlier = core_mlier;
          s_mcand = core_mcand;
        end
        if (resp_valid != 0) begin
          if (exp_q.size() == 0) check("unexpected_resp", 64'(resp_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("resp_valid",   64'(resp_valid), 64'd1 << e.idx);
            check("resp_product", resp_product,    e.prod);
            check("resp_err",     64'(resp_err),   64'(e.err));
            $display("resp: req %0d product %h err %0d", e.idx, resp_product, resp_err);
          end
          t_resp = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_mlier = '0; req_mcand = '0;
    core_spur = 1'b0; core_hang = 1'b0; core_lat = 4;
    tick(3);
    req_valid = 4'b1111;
    #1;
    check_outputs_zero("reset");
    req_valid = '0;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Single request from requester 2 with a 32-cycle core.
    core_lat = 32;
    request(2, 32'd7, 32'd6, 64'd42);
    drain("t1_drain", 200);
    check("t1_start_latency", 64'(t_start - t_ready), 64'd1);
    check("t1_resp_latency",  64'(t_resp - t_ready),  64'd34);
    check("t1_core_mlier",    64'(s_mlier), 64'd7);
    check("t1_core_mcand",    64'(s_mcand), 64'd6);

    // All four from reset; requester 0 comes back right after its response.
    rst = 1'b1; tick(2); rst = 1'b0; tick(1);
    core_lat = 5;
    request(0, 32'd3, 32'd5, 64'd15);
    request(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    request(2, 32'd0, 32'h1234, 64'd0);
    request(3, 32'h10000, 32'h10000, 64'h0000000100000000);
    begin
      int k = 0;
      while (k < 100) begin
        @(negedge clk);
        if (resp_valid[0]) break;
        k++;
      end
      check("t2_resp0_seen", 64'(k < 100), 64'd1);
    end
    @(posedge clk); #2;
    request(0, 32'h12345678, 32'd16, 64'h0000000123456780);
    drain("t2_drain", 300);

    // Spurious done during ISSUE must be ignored.
    core_lat = 6;
    request(3, 32'd1000, 32'd1000, 64'd1000000);
    wait_start("t3_start_seen");
    core_spur = 1'b1;
    @(posedge clk); #1;
    core_spur = 1'b0;
    drain("t3_drain", 100);
    check("t3_resp_latency", 64'(t_resp - t_ready), 64'd8);

    // Stray done while IDLE produces nothing.
    tick(1);
    core_spur = 1'b1;
    tick(1);
    core_spur = 1'b0;
    tick(3);
    check("idle_spur_busy", 64'(busy), 64'd0);

    // Asynchronous reset in the middle of WAIT.
    core_lat = 20;
    request(1, 32'd11, 32'd13, 64'd143);
    wait_start("t4_start_seen");
    tick(5);
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    exp_q.delete();
    grant_q.delete();
    tick(2);
    rst = 1'b0;
    tick(25);
    check("t4_idle_after_rst", 64'(busy), 64'd0);
    request(1, 32'd21, 32'd2, 64'd42);
    request(3, 32'd5, 32'd5, 64'd25);
    drain("t4_drain", 100);

`ifdef MULT_ARB_WDOG_EN
    // Core never answers: abort after 64 WAIT cycles.
    begin
      exp_t e;
      core_hang = 1'b1;
      req_mlier[2*WIDTH +: WIDTH] = 32'd9;
      req_mcand[2*WIDTH +: WIDTH] = 32'd9;
      req_valid[2] = 1'b1;
      e.idx = 2; e.prod = 64'd0; e.err = 1'b1;
      grant_q.push_back(2);
      exp_q.push_back(e);
      drain("t5_wdog_drain", 200);
      check("t5_wdog_latency", 64'(t_resp - t_ready), 64'd66);
      core_hang = 1'b0;
      core_spur = 1'b1;
      tick(1);
      core_spur = 1'b0;
      tick(3);
      check("t5_late_done_busy", 64'(busy), 64'd0);
      core_lat = 3;
      request(2, 32'd9, 32'd9, 64'd81);
      drain("t5_restart_drain", 100);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin controller that shares one sequential 32-bit multiplier core (start/done handshake, multi-cycle shift-add) among NREQ requesters. It accepts operand pairs from requesters and issues them to the core one at a time. It returns the 64-bit product to the originating requester with a one-cycle response pulse. It sits between the requester logic and the multiplier core, whose product feeds the 7-segment decode path.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 32: operand width; product is 2*WIDTH.
- TIMEOUT, 64: maximum cycles in WAIT before abort (used only with the watchdog compiled in).

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation request; held until accepted.
- req_mlier  in  NREQ*WIDTH  flattened multipliers; slice i belongs to requester i.
- req_mcand  in  NREQ*WIDTH  flattened multiplicands.
- req_ready  out  NREQ  one-hot accept pulse; operands are latched on this cycle.
- resp_valid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
- resp_product  out  2*WIDTH  registered product; valid only while any resp_valid bit is high.
- resp_err  out  1  high with resp_valid when the operation was aborted by the watchdog.
- core_start  out  1  one-cycle start pulse to the multiplier core.
- core_mlier, core_mcand  out  WIDTH  latched operands; stable from core_start through core_done.
- core_done  in  1  core completion pulse.
- core_product  in  2*WIDTH  core result; sampled on core_done.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the grant goes to the first set bit at or after rr_ptr, searching in ascending order and wrapping modulo NREQ.
  - The granted requester's req_ready is asserted combinationally that cycle.
  - Its operands are latched into core_mlier/core_mcand, and the grant index is stored.
  - rr_ptr becomes grant+1, wrapping NREQ-1 to 0.
  - Next state is ISSUE.
- ISSUE: core_start is high for exactly one cycle; next state is WAIT.
- WAIT: hold until core_done == 1, then register core_product into resp_product and go to RESP. core_done is ignored in every state except WAIT.
- RESP: resp_valid[grant] is high for one cycle; return to IDLE. No new grant is issued in RESP.
- Requesters not granted keep req_valid asserted and receive no req_ready.
- A requester that drops req_valid before being granted is simply skipped.
- Products are unsigned, full 2*WIDTH with no truncation. Zero operands still run the full sequence and return 0.
- Reset (any state, including mid-operation):
  - state = IDLE, rr_ptr = 0.
  - All outputs = 0: req_ready, resp_valid, resp_product, resp_err, core_start, core_mlier, core_mcand, busy.
  - The in-flight operation is discarded with no response.

## Timing
- Accept at cycle T (req_ready high).
- core_start at T+1.
- If core_done arrives at cycle T+1+L (L ≥ 1), resp_valid and resp_product appear at T+2+L.
- The earliest next accept is T+3+L, giving a throughput of one operation per L+3 cycles.
- A requester may reassert req_valid on the cycle after resp_valid; rr_ptr ensures the other pending requesters are served first.
- All outputs are registered except req_ready, which is a combinational decode of the IDLE state, req_valid and rr_ptr.

## Configuration
- MULT_ARB_WDOG_EN defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT without core_done, the FSM goes to RESP with resp_product = 0 and resp_err = 1.
  - A late core_done is ignored outside WAIT. The next core_start restarts the core.
- MULT_ARB_WDOG_EN undefined: there is no counter, WAIT is unbounded, and resp_err is tied to 0. The port list is identical in both builds.

## Structure
- Package mult_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - default WIDTH/NREQ constants;
  - the product width localparam (2*WIDTH).
- Sub-module rr_arbiter (NREQ): takes the request vector and rr_ptr and returns a one-hot grant and a binary index. It is purely combinational.
- The top holds the FSM, operand/product registers, rr_ptr and the watchdog counter.

## Test plan
- Single request, requester 2, mlier=7, mcand=6, core model L=32: req_ready[2] at T, core_start at T+1, resp_valid=4'b0100 with product 42 at T+34.
- All four requesting from reset: grants in order 0,1,2,3. Requester 0 re-requests immediately and is served only after 3. rr_ptr wraps from 3 to 0.
- Operands 32'hFFFFFFFF × 32'hFFFFFFFF: resp_product = 64'hFFFFFFFE00000001. Zero × 32'h1234: resp_product = 0.
- rst asserted mid-WAIT for requester 1: all outputs are 0 immediately (asynchronous) and no resp_valid follows. After release, requester 1 re-requests and completes correctly, with grant order restarting at 0.
- WDOG_EN build, TIMEOUT=64, core never asserts done: resp_valid with resp_err=1 and product 0 after 64 WAIT cycles. A stray core_done in IDLE produces no response.
- core_done pulsed during ISSUE (spurious): ignored; the FSM stays in WAIT until the real done.
